// File: rtl/ca_ctrl_mc_if.sv
// rtl/ca_ctrl_mc_if.sv - cache-array and memory handshake bundle for the i-cache controller
interface ca_ctrl_mc_if #(
   parameter int CACHE_ENTRIES = 8,
   parameter int AW            = $clog2(CACHE_ENTRIES)
) ();
   logic                     cache_hit;
   logic [CACHE_ENTRIES-1:0] cache_valid;
   logic                     branch_or_jump;
   logic                     flush_all;
   logic                     mem_ack;
   logic                     cache_read;
   logic                     cache_write_;
   logic [AW-1:0]            cache_w_addr;
   logic                     new_valid;
   logic                     cache_stall;
   logic                     mem_req;
   logic                     mem_timeout;

   modport master (
      input  cache_hit, cache_valid, branch_or_jump, flush_all, mem_ack,
      output cache_read, cache_write_, cache_w_addr, new_valid, cache_stall,
             mem_req, mem_timeout
   );

   modport slave (
      output cache_hit, cache_valid, branch_or_jump, flush_all, mem_ack,
      input  cache_read, cache_write_, cache_w_addr, new_valid, cache_stall,
             mem_req, mem_timeout
   );
endinterface

// File: rtl/ca_ctrl_mc.sv
// rtl/ca_ctrl_mc.sv - i-cache miss/evict/fill/flush controller with memory timeout
// Optional hit/miss/timeout counters are built when CA_CTRL_STATS_EN is defined.
module ca_ctrl_mc #(
   parameter int CACHE_ENTRIES   = 8,
   parameter int CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES)-1,
   parameter int MEM_TIMEOUT     = 15,
   parameter int TO_W            = $clog2(MEM_TIMEOUT+1)
`ifdef CA_CTRL_STATS_EN
   ,
   parameter int STAT_W          = 16
`endif
) (
   input  logic         clk,
   input  logic         rst,
   ca_ctrl_mc_if.master bus
`ifdef CA_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_hits_o,
   output logic [STAT_W-1:0] stat_misses_o,
   output logic [STAT_W-1:0] stat_timeouts_o
`endif
);
   localparam int AW = CACHE_ADDR_LEFT + 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] EVICT = 3'd1;
   localparam logic [2:0] REQ   = 3'd2;
   localparam logic [2:0] FILL  = 3'd3;
   localparam logic [2:0] FLUSH = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0] victim_q, victim_d;
   logic [AW-1:0] flush_cnt_q, flush_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic          flush_pend_q, flush_pend_d;
   logic [AW-1:0] free_idx;
   logic          free_any;
   logic          miss_start;

   // Lowest-index invalid entry; scanning downward lets the lowest index win.
   always_comb begin
      free_idx = '0;
      free_any = 1'b0;
      for (int i = CACHE_ENTRIES-1; i >= 0; i--) begin
         if (!bus.cache_valid[i]) begin
            free_idx = AW'(i);
            free_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      victim_d         = victim_q;
      flush_cnt_d      = flush_cnt_q;
      to_cnt_d         = '0;
      flush_pend_d     = flush_pend_q | bus.flush_all;
      miss_start       = 1'b0;
      bus.cache_read   = 1'b1;
      bus.cache_write_ = 1'b1;
      bus.cache_w_addr = '0;
      bus.new_valid    = 1'b0;
      bus.cache_stall  = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst so outputs hold their reset values while reset is asserted.
            if (!rst) begin
               if (flush_pend_q || bus.flush_all) begin
                  bus.cache_stall = 1'b1;
                  flush_pend_d    = 1'b0;
                  state_d         = FLUSH;
               end else if (!bus.cache_hit && !bus.branch_or_jump) begin
                  bus.cache_stall = 1'b1;
                  miss_start      = 1'b1;
                  victim_d        = free_any ? free_idx : rr_ptr_q;
                  state_d         = free_any ? REQ : EVICT;
               end
            end
         end
         EVICT: begin
            bus.cache_read   = 1'b0;
            bus.cache_write_ = 1'b0;
            bus.cache_w_addr = victim_q;
            bus.cache_stall  = 1'b1;
            rr_ptr_d         = rr_ptr_q + AW'(1);
            state_d          = bus.branch_or_jump ? IDLE : REQ;
         end
         REQ: begin
            bus.mem_req     = 1'b1;
            bus.cache_stall = 1'b1;
            bus.cache_read  = 1'b0;
            if (bus.branch_or_jump) begin
               state_d = IDLE;
            end else if (bus.mem_ack) begin
               state_d = FILL;
            end else if (to_cnt_q == TO_W'(MEM_TIMEOUT-1)) begin
               bus.mem_timeout = 1'b1;
               state_d         = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         FILL: begin
            bus.cache_read   = 1'b0;
            bus.cache_write_ = 1'b0;
            bus.cache_w_addr = victim_q;
            bus.new_valid    = 1'b1;
            bus.cache_stall  = 1'b1;
            state_d          = IDLE;
         end
         FLUSH: begin
            bus.cache_read   = 1'b0;
            bus.cache_write_ = 1'b0;
            bus.cache_w_addr = flush_cnt_q;
            bus.cache_stall  = 1'b1;
            flush_cnt_d      = flush_cnt_q + AW'(1);
            if (flush_cnt_q == AW'(CACHE_ENTRIES-1)) begin
               flush_cnt_d = '0;
               rr_ptr_d    = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         victim_q     <= '0;
         to_cnt_q     <= '0;
         flush_cnt_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         victim_q     <= victim_d;
         to_cnt_q     <= to_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

`ifdef CA_CTRL_STATS_EN
   logic [STAT_W-1:0] stat_hits_q, stat_misses_q, stat_timeouts_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hits_q     <= '0;
         stat_misses_q   <= '0;
         stat_timeouts_q <= '0;
      end else if (state_q == FLUSH) begin
         stat_hits_q     <= '0;
         stat_misses_q   <= '0;
         stat_timeouts_q <= '0;
      end else begin
         if (state_q == IDLE && bus.cache_hit && !bus.branch_or_jump && !flush_pend_q &&
             stat_hits_q != '1)
            stat_hits_q <= stat_hits_q + STAT_W'(1);
         if (miss_start && stat_misses_q != '1)
            stat_misses_q <= stat_misses_q + STAT_W'(1);
         if (bus.mem_timeout && stat_timeouts_q != '1)
            stat_timeouts_q <= stat_timeouts_q + STAT_W'(1);
      end
   end

   assign stat_hits_o     = stat_hits_q;
   assign stat_misses_o   = stat_misses_q;
   assign stat_timeouts_o = stat_timeouts_q;
`endif
endmodule

// File: tb/tb_ca_ctrl_mc.sv
// tb/tb_ca_ctrl_mc.sv - vector table, reset corner cases and transaction-level random model
module tb_ca_ctrl_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ca_ctrl_mc_if #(.CACHE_ENTRIES(8)) bus ();

`ifdef CA_CTRL_STATS_EN
   logic [15:0] stat_hits, stat_misses, stat_timeouts;
   ca_ctrl_mc dut (.clk(clk), .rst(rst), .bus(bus), .stat_hits_o(stat_hits),
                   .stat_misses_o(stat_misses), .stat_timeouts_o(stat_timeouts));
`else
   ca_ctrl_mc dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   // Output word: {read, write_, w_addr[2:0], new_valid, stall, mem_req, mem_timeout}
   localparam logic [8:0] IDLE_W = 9'b1_1_000_0_0_0_0;
   localparam logic [8:0] MISS_W = 9'b1_1_000_0_1_0_0;
   localparam logic [8:0] REQ_W  = 9'b0_1_000_0_1_1_0;
   localparam logic [8:0] TOUT_W = 9'b0_1_000_0_1_1_1;

   typedef struct {
      logic       hit;
      logic [7:0] valid;
      logic       bj;
      logic       fl;
      logic       ack;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_rr   = 0;

   logic [8:0] obs;
   assign obs = {bus.cache_read, bus.cache_write_, bus.cache_w_addr, bus.new_valid,
                 bus.cache_stall, bus.mem_req, bus.mem_timeout};

   function automatic logic [8:0] wr_w(int a, logic nv);
      return {1'b0, 1'b0, 3'(a), nv, 1'b1, 1'b0, 1'b0};
   endfunction

   function automatic void add(logic h, logic [7:0] v, logic j, logic f, logic a, logic [8:0] e);
      vec_t t;
      t.hit = h; t.valid = v; t.bj = j; t.fl = f; t.ack = a; t.exp = e;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] actual=%b required=%b", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic [7:0] v, input logic j, input logic f, input logic a);
      bus.cache_hit = h; bus.cache_valid = v; bus.branch_or_jump = j;
      bus.flush_all = f; bus.mem_ack = a;
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         drive(tbl[i].hit, tbl[i].valid, tbl[i].bj, tbl[i].fl, tbl[i].ack);
         @(negedge clk);
         chk(tag, i, obs, tbl[i].exp);
      end
      tbl.delete();
   endtask

   // Random miss transaction: expected cycles derived from victim choice and ack/abort timing.
   function automatic void gen_miss();
      logic [7:0] v;
      int vic, d, b;
      logic a, j;
      v = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      vic = m_rr;
      for (int i = 7; i >= 0; i--) if (!v[i]) vic = i;
      add(1'b0, v, 1'b0, 1'b0, 1'b0, MISS_W);
      if (v == 8'hFF) begin
         j = ($urandom_range(0, 4) == 0);
         add(1'b1, v, j, 1'b0, 1'b0, wr_w(vic, 1'b0));
         m_rr = (m_rr + 1) % 8;
         if (j) begin
            add(1'b1, v, 1'b0, 1'b0, 1'b0, IDLE_W);
            return;
         end
      end
      d = $urandom_range(0, 17);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : 99;
      for (int k = 0; k < 15; k++) begin
         a = (k == d);
         j = (k == b);
         add(1'b1, v, j, 1'b0, a, (k == 14 && !a && !j) ? TOUT_W : REQ_W);
         if (a || j || k == 14) begin
            if (a && !j) add(1'b1, v, 1'b0, 1'b0, 1'b0, wr_w(vic, 1'b1));
            break;
         end
      end
      add(1'b1, v, 1'b0, 1'b0, 1'($urandom_range(0, 1)), IDLE_W);
   endfunction

   function automatic void gen_flush();
      add(1'($urandom_range(0, 1)), 8'hFF, 1'b0, 1'b1, 1'b0, MISS_W);
      for (int i = 0; i < 8; i++)
         add(1'b1, 8'hFF, 1'($urandom_range(0, 1)), 1'b0, 1'b0, wr_w(i, 1'b0));
      m_rr = 0;
      add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, IDLE_W);
   endfunction

   function automatic void gen_hit();
      if ($urandom_range(0, 1) == 1)
         add(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), IDLE_W);
      else
         add(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, IDLE_W);
   endfunction

   initial begin
      drive(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", 0, obs, IDLE_W);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.cache_hit = 1'b1;

      // Non-full miss, ack on 2nd REQ cycle, fill entry 4
      add(0, 8'h0F, 0, 0, 0, MISS_W);
      add(1, 8'h0F, 0, 0, 0, REQ_W);
      add(1, 8'h0F, 0, 0, 1, REQ_W);
      add(1, 8'h0F, 0, 0, 0, wr_w(4, 1'b1));
      add(1, 8'h0F, 0, 0, 0, IDLE_W);
      // Full misses: round-robin evict 0,1,2,3
      for (int k = 0; k < 4; k++) begin
         add(0, 8'hFF, 0, 0, 0, MISS_W);
         add(1, 8'hFF, 0, 0, 0, wr_w(k, 1'b0));
         add(1, 8'hFF, 0, 0, 1, REQ_W);
         add(1, 8'hFF, 0, 0, 0, wr_w(k, 1'b1));
      end
      add(1, 8'hFF, 0, 0, 0, IDLE_W);
      // Timeout after 15 REQ cycles, no write
      add(0, 8'h0F, 0, 0, 0, MISS_W);
      for (int k = 0; k < 14; k++) add(1, 8'h0F, 0, 0, 0, REQ_W);
      add(1, 8'h0F, 0, 0, 0, TOUT_W);
      add(1, 8'h0F, 0, 0, 0, IDLE_W);
      // Branch with ack on 2nd REQ cycle; later stale ack ignored
      add(0, 8'h0F, 0, 0, 0, MISS_W);
      add(1, 8'h0F, 0, 0, 0, REQ_W);
      add(1, 8'h0F, 1, 0, 1, REQ_W);
      add(1, 8'h0F, 0, 0, 1, IDLE_W);
      add(1, 8'h0F, 0, 0, 0, IDLE_W);
      // Branch with a miss in IDLE does not stall
      add(0, 8'hFF, 1, 0, 0, IDLE_W);
      // Flush pulsed during REQ: fill completes, then 8 flush writes
      add(0, 8'h0F, 0, 0, 0, MISS_W);
      add(1, 8'h0F, 0, 1, 0, REQ_W);
      add(1, 8'h0F, 0, 0, 1, REQ_W);
      add(1, 8'h0F, 0, 0, 0, wr_w(4, 1'b1));
      add(1, 8'h0F, 0, 0, 0, MISS_W);
      for (int i = 0; i < 8; i++) add(1, 8'h0F, 0, 0, 0, wr_w(i, 1'b0));
      add(1, 8'h0F, 0, 0, 0, IDLE_W);
      // rr_ptr back at 0 after flush
      add(0, 8'hFF, 0, 0, 0, MISS_W);
      add(1, 8'hFF, 0, 0, 0, wr_w(0, 1'b0));
      add(1, 8'hFF, 0, 0, 1, REQ_W);
      add(1, 8'hFF, 0, 0, 0, wr_w(0, 1'b1));
      add(1, 8'hFF, 0, 0, 0, IDLE_W);
      run_tbl("tbl");

      // Reset asserted during EVICT of entry 1
      add(0, 8'hFF, 0, 0, 0, MISS_W);
      add(1, 8'hFF, 0, 0, 0, wr_w(1, 1'b0));
      run_tbl("pre_rst");
      #1;
      rst = 1'b1;
      bus.cache_hit = 1'b0;
      #1;
      chk("rst_evict", 0, obs, IDLE_W);
      @(posedge clk); #1;
      chk("rst_hold", 0, obs, IDLE_W);
      rst = 1'b0;
      bus.cache_hit = 1'b1;
      add(0, 8'hFF, 0, 0, 0, MISS_W);
      add(1, 8'hFF, 0, 0, 0, wr_w(0, 1'b0));
      add(1, 8'hFF, 0, 0, 1, REQ_W);
      add(1, 8'hFF, 0, 0, 0, wr_w(0, 1'b1));
      add(1, 8'hFF, 0, 0, 0, IDLE_W);
      run_tbl("post_rst");

      gen_flush();
      for (int t = 0; t < 200; t++) begin
         case ($urandom_range(0, 5))
            0:       gen_flush();
            1, 2:    gen_hit();
            default: gen_miss();
         endcase
      end
      run_tbl("rnd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
